// File: rtl/alu_unit.sv
// alu_unit: 8-bit ALU stage feeding the accumulator's ALU input.
//   ADD/SUB/AND/OR/XOR/SHL (and NOP) complete in one cycle.
//   MUL is a WIDTH-iteration shift-add that raises busy until it completes.
//   done pulses for one cycle each time result/zero/carry are written.
// Build option: define ALU_DIV_EN to turn op=111 into an unsigned restoring
//   divide with the same timing as MUL. When it is left undefined, op=111 is
//   a one-cycle NOP (result = a), and neither the DIV state nor the divider
//   datapath is built.
module alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             zero,
    output logic             carry
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    // The counter only has to reach WIDTH-1. The +1 keeps it at least
    // one bit wide even when WIDTH is 1.
    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
    } state_e;
`endif

    // Single-cycle operations. The result is returned as {carry, result}.
    function automatic logic [WIDTH:0] alu_single(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb
    );
        logic [WIDTH:0] r;
        r = '0;
        case (f_op)
            OP_ADD: r = {1'b0, fa} + {1'b0, fb};
            OP_SUB: r = {(fa < fb), fa - fb};
            OP_AND: r = {1'b0, fa & fb};
            OP_OR:  r = {1'b0, fa | fb};
            OP_XOR: r = {1'b0, fa ^ fb};
            OP_SHL: r = {fa, 1'b0};
`ifdef ALU_DIV_EN
            // Only divide-by-zero reaches this path. It saturates and flags.
            OP_DIV: r = {1'b1, {WIDTH{1'b1}}};
`else
            OP_DIV: r = {1'b0, fa};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // Control registers
    state_e                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   done_q,   done_d;

    // Architectural outputs
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   zero_q,   zero_d;
    logic                   carry_q,  carry_d;

    // Multiplier datapath: partial product, shifting multiplicand,
    // and a multiplier that is consumed one LSB at a time.
    logic [2*WIDTH-1:0]     acc_q,    acc_d;
    logic [2*WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     mul_sum;

    logic [WIDTH:0]         single_res;
    logic                   start_multi;

    assign single_res = alu_single(op, a, b);
    assign mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef ALU_DIV_EN
    // Restoring divider. The dividend shifts out of quo_q into the partial
    // remainder, and quotient bits shift in from the right.
    logic [WIDTH-1:0]       rem_q,    rem_d;
    logic [WIDTH-1:0]       quo_q,    quo_d;
    logic [WIDTH-1:0]       dvsr_q,   dvsr_d;
    logic [WIDTH:0]         div_sh;
    logic [WIDTH:0]         div_diff;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_quo_next;

    assign div_sh       = {rem_q, quo_q[WIDTH-1]};
    assign div_diff     = div_sh - {1'b0, dvsr_q};
    // The partial remainder is always below the divisor, so bit WIDTH of
    // the difference is a reliable sign bit.
    assign div_ge       = ~div_diff[WIDTH];
    assign div_quo_next = {quo_q[WIDTH-2:0], div_ge};
    assign start_multi  = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
`else
    assign start_multi  = (op == OP_MUL);
`endif

    // Next-state logic: FSM transitions, iteration steps and result writes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`ifdef ALU_DIV_EN
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_multi) begin
                        // Latch the operands now. Later changes on a/b
                        // are ignored for the rest of the operation.
                        cnt_d = '0;
`ifdef ALU_DIV_EN
                        if (op == OP_DIV) begin
                            state_d = S_DIV;
                            rem_d   = '0;
                            quo_d   = a;
                            dvsr_d  = b;
                        end else begin
                            state_d  = S_MUL;
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a};
                            mplier_d = b;
                        end
`else
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
`endif
                    end else begin
                        result_d = single_res[WIDTH-1:0];
                        carry_d  = single_res[WIDTH];
                        zero_d   = (single_res[WIDTH-1:0] == '0);
                        done_d   = 1'b1;
                    end
                end
            end

            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    // The last iteration's sum is the full product.
                    result_d = mul_sum[WIDTH-1:0];
                    carry_d  = |mul_sum[2*WIDTH-1:WIDTH];
                    zero_d   = (mul_sum[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end

`ifdef ALU_DIV_EN
            S_DIV: begin
                rem_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                quo_d = div_quo_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    result_d = div_quo_next;
                    carry_d  = 1'b0;
                    zero_d   = (div_quo_next == '0);
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers. Asynchronous reset aborts any operation
    // in progress and clears every output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`ifdef ALU_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`ifdef ALU_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
`endif
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign busy   = (state_q != S_IDLE);

endmodule
